// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_unit
// Brief    : Branch condition evaluation, branch target generation and PC
//            register with increment / direct load.
// Revision : 1.0
// ============================================================================
module branch_pc_unit #(
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 19,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] bus_value,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_out,
  output logic              con_out,
  output logic              busy,
  output logic              done
);

  localparam int IRF_W = OFFSET_W + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_CALC   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t            state_q,  state_d;
  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] value_q,  value_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [IRF_W-1:0]  ir_q,     ir_d;
  logic              con_q,    con_d;
  logic              done_q,   done_d;

  logic [1:0]        w_cond;
  logic              w_cond_true;
  logic [DATA_W-1:0] w_offset;
  logic              w_unused_ir;

  // Only the condition and offset fields are kept; upper IR bits are don't-care.
  assign w_unused_ir = ^ir[DATA_W-1:IRF_W];

  assign w_cond   = ir_q[IRF_W-1:OFFSET_W];
  assign w_offset = {{(DATA_W-OFFSET_W){ir_q[OFFSET_W-1]}}, ir_q[OFFSET_W-1:0]};

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      2'b00:   w_cond_true = (value_q == '0);
      2'b01:   w_cond_true = (value_q != '0);
      2'b10:   w_cond_true = ~value_q[DATA_W-1];
      default: w_cond_true = value_q[DATA_W-1];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    value_d  = value_q;
    target_d = target_q;
    ir_d     = ir_q;
    con_d    = con_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A direct load wins over a branch start, which wins over increment.
        if (pc_load) begin
          pc_d = pc_in;
        end else if (start) begin
          ir_d    = ir[IRF_W-1:0];
          value_d = bus_value;
          state_d = S_EVAL;
        end else if (pc_inc) begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_EVAL: begin
        con_d   = w_cond_true;
        state_d = S_CALC;
      end
      S_CALC: begin
        target_d = pc_q + w_offset;
        state_d  = S_UPDATE;
      end
      default: begin
        if (con_q) pc_d = target_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      value_q  <= '0;
      target_q <= '0;
      ir_q     <= '0;
      con_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      value_q  <= value_d;
      target_q <= target_d;
      ir_q     <= ir_d;
      con_q    <= con_d;
      done_q   <= done_d;
    end
  end

  assign pc_out  = pc_q;
  assign con_out = con_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pc_unit
// Brief    : Self-checking bench for branch_pc_unit against a reference model.
// Revision : 1.0
// ============================================================================
module tb_branch_pc_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] bus_value = '0;
  logic        pc_inc = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out;
  logic        con_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference model: branch outcome resolved at acceptance, made visible later.
  logic [31:0] m_pc;
  logic        m_con;
  logic        m_done;
  logic        m_take;
  logic [31:0] m_tgt;
  int          m_left;

  branch_pc_unit dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .bus_value(bus_value),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_in(pc_in),
    .pc_out(pc_out), .con_out(con_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic cond_ok(input logic [31:0] i, input logic [31:0] v);
    case (i[20:19])
      2'd0:    return v == 0;
      2'd1:    return v != 0;
      2'd2:    return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  function automatic logic [31:0] make_ir(input int c, input int off);
    logic [31:0] r;
    r = $urandom;
    r[20:19] = 2'(c);
    r[18:0]  = 19'(off);
    return r;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_con = 1'b0; m_done = 1'b0; m_left = 0;
    m_take = 1'b0; m_tgt = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic s, input logic [31:0] i, input logic [31:0] b,
                      input logic inc, input logic ld, input logic [31:0] pin);
    logic signed [18:0] off;
    start = s; ir = i; bus_value = b; pc_inc = inc; pc_load = ld; pc_in = pin;
    @(posedge clock);
    m_done = 1'b0;
    if (m_left == 0) begin
      if (ld) m_pc = pin;
      else if (s) begin
        off    = i[18:0];
        m_take = cond_ok(i, b);
        m_tgt  = m_pc + 32'(int'(off));
        m_left = 3;
      end else if (inc) m_pc = m_pc + 1;
    end else begin
      if (m_left == 3) m_con = m_take;
      if (m_left == 1) begin
        if (m_take) m_pc = m_tgt;
        m_done = 1'b1;
      end
      m_left = m_left - 1;
    end
    #1;
    start = 0; pc_inc = 0; pc_load = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, 0, 0, '0);
  endtask

  task automatic do_clear();
    #2 clear = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({pc_out, con_out, busy, done} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_clear: pc=%h con=%b busy=%b done=%b, want pc=0 con=0 busy=0 done=0",
               pc_out, con_out, busy, done);
    end
    #1 clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pc_out, con_out, busy, done} !== 35'h0) begin
      errors++;
      $display("FAIL reset: pc=%h con=%b busy=%b done=%b, want all zero", pc_out, con_out, busy, done);
    end
    @(negedge clock) clear = 1'b0;
    @(posedge clock); #1;
    model_reset();
  endtask

  task automatic test_taken_zero();
    int busy_cycles;
    busy_cycles = 0;
    step(0, '0, '0, 0, 1, 32'h10);
    step(1, make_ir(0, 5), 32'h0, 0, 0, '0);
    if (busy) busy_cycles++;
    step(0, '0, '0, 0, 0, '0);
    if (busy) busy_cycles++;
    checks++;
    if (con_out !== 1'b1) begin
      errors++; $display("FAIL zero_con: con=%b want 1", con_out);
    end
    for (int k = 0; k < 2; k++) begin
      step(0, '0, '0, 0, 0, '0);
      if (busy) busy_cycles++;
    end
    checks++;
    if (pc_out !== 32'h15 || done !== 1'b1) begin
      errors++; $display("FAIL zero_pc: pc=%h done=%b want pc=00000015 done=1", pc_out, done);
    end
    checks++;
    if (busy_cycles != 3) begin
      errors++; $display("FAIL zero_busy_len: busy cycles=%0d want 3", busy_cycles);
    end
    idle(1);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_not_taken();
    step(0, '0, '0, 0, 1, 32'h10);
    step(1, make_ir(1, 5), 32'h0, 0, 0, '0);
    step(0, '0, '0, 0, 0, '0);
    checks++;
    if (con_out !== 1'b0) begin
      errors++; $display("FAIL nonzero_con: con=%b want 0", con_out);
    end
    idle(2);
    checks++;
    if (pc_out !== 32'h10 || done !== 1'b1) begin
      errors++; $display("FAIL nonzero_pc: pc=%h done=%b want pc=00000010 done=1", pc_out, done);
    end
  endtask

  task automatic test_sign();
    step(0, '0, '0, 0, 1, 32'h10);
    step(1, make_ir(3, 19'h7FFFF), 32'h8000_0000, 0, 0, '0);
    idle(3);
    checks++;
    if (pc_out !== 32'h0F || con_out !== 1'b1) begin
      errors++; $display("FAIL minus_back: pc=%h con=%b want pc=0000000f con=1", pc_out, con_out);
    end
    step(0, '0, '0, 0, 1, 32'h10);
    step(1, make_ir(2, 19'h7FFFF), 32'h8000_0000, 0, 0, '0);
    idle(3);
    checks++;
    if (pc_out !== 32'h10 || con_out !== 1'b0) begin
      errors++; $display("FAIL plus_neg: pc=%h con=%b want pc=00000010 con=0", pc_out, con_out);
    end
  endtask

  task automatic test_wrap_priority();
    step(0, '0, '0, 0, 1, 32'hFFFF_FFFF);
    step(0, '0, '0, 1, 0, '0);
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: pc=%h want 00000000", pc_out);
    end
    step(1, make_ir(0, 7), 32'h0, 0, 1, 32'h1234_5678);
    checks++;
    if (pc_out !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++; $display("FAIL load_over_start: pc=%h busy=%b want pc=12345678 busy=0", pc_out, busy);
    end
    step(1, make_ir(1, 2), 32'h0, 1, 0, '0);
    checks++;
    if (pc_out !== 32'h1234_5678 || busy !== 1'b1) begin
      errors++; $display("FAIL start_over_inc: pc=%h busy=%b want pc=12345678 busy=1", pc_out, busy);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    step(0, '0, '0, 0, 1, 32'h100);
    step(1, make_ir(0, 19'h40), 32'h0, 0, 0, '0);
    step(1, make_ir(1, 1), 32'h5, 1, 0, '0);
    step(0, '0, '0, 1, 1, 32'hDEAD_0000);
    step(1, make_ir(1, 1), 32'h5, 0, 1, 32'hBEEF_0000);
    checks++;
    if (pc_out !== 32'h140 || done !== 1'b1 || con_out !== 1'b1) begin
      errors++; $display("FAIL busy_ignore: pc=%h done=%b con=%b want pc=00000140 done=1 con=1",
                         pc_out, done, con_out);
    end
    step(1, make_ir(3, 3), 32'h1, 0, 0, '0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    idle(3);
    checks++;
    if (pc_out !== 32'h140 || con_out !== 1'b0) begin
      errors++; $display("FAIL b2b_result: pc=%h con=%b want pc=00000140 con=0", pc_out, con_out);
    end
  endtask

  task automatic test_clear_each_state();
    for (int st = 0; st < 4; st++) begin
      step(0, '0, '0, 0, 1, 32'h20);
      step(1, make_ir(0, 9), 32'h0, 0, 0, '0);
      idle(st);
      do_clear();
    end
  endtask

  task automatic test_random();
    logic [31:0] b, i;
    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step($urandom_range(0, 2) == 0, i, b, $urandom_range(0, 2) == 0,
           $urandom_range(0, 6) == 0, $urandom);
      checks++;
      if ({pc_out, con_out, busy, done} !== {m_pc, m_con, m_left != 0, m_done}) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h con=%b busy=%b done=%b want pc=%h con=%b busy=%b done=%b",
                 n, pc_out, con_out, busy, done, m_pc, m_con, m_left != 0, m_done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_taken_zero();
    test_not_taken();
    test_sign();
    test_wrap_priority();
    test_back_to_back();
    test_clear_each_state();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
